// File: rtl/dict_finder_pkg.sv
// Shared types and constants for the dictionary finder.
package dict_finder_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SKIP,
      ST_TOK,
      ST_LNK0,
      ST_LNK1,
      ST_LEN,
      ST_NAME,
      ST_OP,
      ST_DONE
   } fnd_state_e;

   localparam logic [15:0] LFA_END = 16'hffff;
   localparam logic [7:0]  ASC_SPC = 8'h20;
   localparam logic [7:0]  ASC_NUL = 8'h00;

   function automatic logic is_delim(input logic [7:0] b);
      return (b != ASC_NUL) && (b <= ASC_SPC);
   endfunction

endpackage

// File: rtl/mb8_io.sv
// 8-bit memory bus: registered address, read data returned one cycle later.
interface mb8_io #(parameter int ASZ = 17) ();
   logic           we;
   logic [ASZ-1:0] ai;
   logic [7:0]     vi;
   logic [7:0]     vo;

   modport master (output we, output ai, output vi, input vo);
   modport slave  (input we, input ai, input vi, output vo);
endinterface

// File: rtl/dict_tokbuf.sv
// Token byte store with an indexed equality compare used during name matching.
module dict_tokbuf #(
   parameter int TKSZ = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    we_i,
   input  logic [$clog2(TKSZ)-1:0] widx_i,
   input  logic [7:0]              wdat_i,
   input  logic [$clog2(TKSZ)-1:0] ridx_i,
   input  logic [7:0]              cmp_i,
   output logic                    eq_o
);

   logic [7:0] buf_q [TKSZ];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < TKSZ; i++) buf_q[i] <= '0;
      end else if (we_i) begin
         buf_q[widx_i] <= wdat_i;
      end
   end

   assign eq_o = (buf_q[ridx_i] == cmp_i);

endmodule

// File: rtl/dict_finder.sv
// Parses one token from the TIB and searches the linked dictionary for it.
// state | meaning
// IDLE  | waiting for en
// SKIP  | skipping leading delimiters
// TOK   | collecting token bytes
// LNK0  | reading link low byte (after refill)
// LNK1  | reading link high byte
// LEN   | comparing entry length with token length
// NAME  | comparing name bytes
// OP    | reading opcode at PFA
// DONE  | results valid, one cycle
module dict_finder
   import dict_finder_pkg::*;
#(
   parameter int ASZ  = 17,
   parameter int TKSZ = 16
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   mb8_io.master          b8_if,
   input  logic           en_i,
   input  logic [ASZ-1:0] tib_ptr_i,
   input  logic [ASZ-1:0] ctx_i,
   output logic           bsy_o,
   output logic           done_o,
   output logic           hit_o,
   output logic           eot_o,
   output logic [7:0]     op_o,
   output logic [ASZ-1:0] pfa_o,
   output logic [7:0]     tok_len_o,
   output logic [ASZ-1:0] next_ptr_o
);

   localparam int IW = $clog2(TKSZ);

   fnd_state_e     state_q, state_d;
   logic [ASZ-1:0] ai_q, ai_d, ctx_q, ctx_d, pfa_q, pfa_d, nxt_q, nxt_d;
   logic           fill_q, fill_d, hit_q, hit_d, eot_q, eot_d;
   logic [15:0]    lnk_q, lnk_d;
   logic [7:0]     len_q, len_d, op_q, op_d, tlen_q, tlen_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           tb_we, tb_eq;
   logic [7:0]     rd;
   logic [ASZ-1:0] ai_inc, cur_addr, lnk_addr;

   assign rd       = b8_if.vo;
   assign ai_inc   = ai_q + ASZ'(1);
   // ai runs one byte ahead of the data being consumed
   assign cur_addr = ai_q - ASZ'(1);
   assign lnk_addr = {{(ASZ-16){1'b0}}, lnk_q};

   dict_tokbuf #(.TKSZ(TKSZ)) u_tokbuf (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .we_i   (tb_we),
      .widx_i (tlen_q[IW-1:0]),
      .wdat_i (rd),
      .ridx_i (idx_q),
      .cmp_i  (rd),
      .eq_o   (tb_eq)
   );

   always_comb begin
      state_d = state_q;
      ai_d    = ai_q;
      fill_d  = 1'b0;
      ctx_d   = ctx_q;
      lnk_d   = lnk_q;
      len_d   = len_q;
      idx_d   = idx_q;
      hit_d   = hit_q;
      eot_d   = eot_q;
      op_d    = op_q;
      pfa_d   = pfa_q;
      tlen_d  = tlen_q;
      nxt_d   = nxt_q;
      tb_we   = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (en_i) begin
               state_d = ST_SKIP;
               ai_d    = tib_ptr_i;
               fill_d  = 1'b1;
               ctx_d   = ctx_i;
               hit_d   = 1'b0;
               eot_d   = 1'b0;
               op_d    = '0;
               pfa_d   = '0;
               tlen_d  = '0;
               nxt_d   = '0;
            end
         end
         ST_SKIP: begin
            ai_d = ai_inc;
            if (!fill_q) begin
               if (rd == ASC_NUL) begin
                  eot_d   = 1'b1;
                  nxt_d   = cur_addr;
                  state_d = ST_DONE;
               end else if (!is_delim(rd)) begin
                  tb_we   = 1'b1;
                  tlen_d  = 8'd1;
                  state_d = ST_TOK;
               end
            end
         end
         ST_TOK: begin
            if (rd == ASC_NUL || is_delim(rd)) begin
               nxt_d = cur_addr;
               if (tlen_q > 8'(TKSZ) || ctx_q[15:0] == LFA_END) begin
                  state_d = ST_DONE;
               end else begin
                  ai_d    = ctx_q;
                  fill_d  = 1'b1;
                  state_d = ST_LNK0;
               end
            end else begin
               ai_d  = ai_inc;
               tb_we = (tlen_q < 8'(TKSZ));
               if (tlen_q != 8'hff) tlen_d = tlen_q + 8'd1;
            end
         end
         ST_LNK0: begin
            ai_d = ai_inc;
            if (!fill_q) begin
               lnk_d[7:0] = rd;
               state_d    = ST_LNK1;
            end
         end
         ST_LNK1: begin
            ai_d        = ai_inc;
            lnk_d[15:8] = rd;
            state_d     = ST_LEN;
         end
         ST_LEN: begin
            if (rd != tlen_q) begin
               if (lnk_q == LFA_END) begin
                  state_d = ST_DONE;
               end else begin
                  ai_d    = lnk_addr;
                  fill_d  = 1'b1;
                  state_d = ST_LNK0;
               end
            end else begin
               ai_d    = ai_inc;
               len_d   = rd;
               idx_d   = '0;
               state_d = ST_NAME;
            end
         end
         ST_NAME: begin
            if (!tb_eq) begin
               if (lnk_q == LFA_END) begin
                  state_d = ST_DONE;
               end else begin
                  ai_d    = lnk_addr;
                  fill_d  = 1'b1;
                  state_d = ST_LNK0;
               end
            end else begin
               ai_d = ai_inc;
               if ({{(8-IW){1'b0}}, idx_q} == len_q - 8'd1) state_d = ST_OP;
               else idx_d = idx_q + 1'b1;
            end
         end
         ST_OP: begin
            hit_d   = 1'b1;
            op_d    = rd;
            pfa_d   = cur_addr;
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         ai_q    <= '0;
         fill_q  <= 1'b0;
         ctx_q   <= '0;
         lnk_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         hit_q   <= 1'b0;
         eot_q   <= 1'b0;
         op_q    <= '0;
         pfa_q   <= '0;
         tlen_q  <= '0;
         nxt_q   <= '0;
      end else begin
         state_q <= state_d;
         ai_q    <= ai_d;
         fill_q  <= fill_d;
         ctx_q   <= ctx_d;
         lnk_q   <= lnk_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         hit_q   <= hit_d;
         eot_q   <= eot_d;
         op_q    <= op_d;
         pfa_q   <= pfa_d;
         tlen_q  <= tlen_d;
         nxt_q   <= nxt_d;
      end
   end

   assign b8_if.we   = 1'b0;
   assign b8_if.vi   = '0;
   assign b8_if.ai   = ai_q;
   assign bsy_o      = !(state_q inside {ST_IDLE, ST_DONE});
   assign done_o     = (state_q == ST_DONE);
   assign hit_o      = hit_q;
   assign eot_o      = eot_q;
   assign op_o       = op_q;
   assign pfa_o      = pfa_q;
   assign tok_len_o  = tlen_q;
   assign next_ptr_o = nxt_q;

endmodule

// File: tb/tb_dict_finder.sv
// Directed bench for dict_finder: small Forth-style dictionary and TIB.
module tb_dict_finder;
   import dict_finder_pkg::*;

   localparam int ASZ = 17;
   localparam logic [7:0] OP_NOP = 8'h10, OP_DUP = 8'h11, OP_DROP = 8'h12,
                          OP_SWAP = 8'h13, OP_ADD = 8'h14, OP_SUB = 8'h15;

   logic           clk_i = 1'b0;
   logic           rst_ni = 1'b0;
   logic           en_i = 1'b0;
   logic [ASZ-1:0] tib_ptr_i = '0;
   logic [ASZ-1:0] ctx_i = '0;
   logic           bsy_o, done_o, hit_o, eot_o;
   logic [7:0]     op_o, tok_len_o;
   logic [ASZ-1:0] pfa_o, next_ptr_o;

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] mem [0:(1<<ASZ)-1];

   mb8_io #(.ASZ(ASZ)) bus ();

   dict_finder #(.ASZ(ASZ), .TKSZ(16)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .b8_if      (bus),
      .en_i       (en_i),
      .tib_ptr_i  (tib_ptr_i),
      .ctx_i      (ctx_i),
      .bsy_o      (bsy_o),
      .done_o     (done_o),
      .hit_o      (hit_o),
      .eot_o      (eot_o),
      .op_o       (op_o),
      .pfa_o      (pfa_o),
      .tok_len_o  (tok_len_o),
      .next_ptr_o (next_ptr_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) bus.vo <= mem[bus.ai];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic put_str(input int a, input string s);
      for (int i = 0; i < s.len(); i++) mem[a + i] = s[i];
   endtask

   task automatic put_entry(input int a, input logic [15:0] lnk, input string nm,
                            input logic [7:0] opc);
      mem[a]     = lnk[7:0];
      mem[a + 1] = lnk[15:8];
      mem[a + 2] = 8'(nm.len());
      put_str(a + 3, nm);
      mem[a + 3 + nm.len()] = opc;
   endtask

   task automatic start(input logic [ASZ-1:0] tib, input logic [ASZ-1:0] cx);
      @(negedge clk_i);
      tib_ptr_i = tib;
      ctx_i     = cx;
      en_i      = 1'b1;
      @(negedge clk_i);
      en_i      = 1'b0;
   endtask

   // lat counts cycles from the en cycle to the done cycle
   task automatic wait_done(input string tag, output int lat);
      bit seen = 0;
      lat = 1;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(posedge clk_i);
         #1;
         lat++;
         if (done_o) seen = 1;
      end
      chk({tag, ".done_seen"}, 32'(seen), 32'd1);
      chk({tag, ".bsy_at_done"}, 32'(bsy_o), 32'd0);
      @(posedge clk_i);
      #1;
      chk({tag, ".done_1cyc"}, 32'(done_o), 32'd0);
   endtask

   task automatic expect_res(input string tag, input logic h, input logic e,
                             input logic [7:0] opc, input logic [ASZ-1:0] pf,
                             input logic [7:0] tl, input logic [ASZ-1:0] np);
      chk({tag, ".hit"}, 32'(hit_o), 32'(h));
      chk({tag, ".eot"}, 32'(eot_o), 32'(e));
      chk({tag, ".op"}, 32'(op_o), 32'(opc));
      chk({tag, ".pfa"}, 32'(pfa_o), 32'(pf));
      chk({tag, ".tok_len"}, 32'(tok_len_o), 32'(tl));
      chk({tag, ".next_ptr"}, 32'(next_ptr_o), 32'(np));
   endtask

   initial begin
      int lat;
      int dn;
      for (int i = 0; i < (1 << ASZ); i++) mem[i] = 8'h00;
      put_str(0, "123 dup + 456 -");
      put_entry('h100, 16'hffff, "nop",  OP_NOP);
      put_entry('h107, 16'h0100, "dup",  OP_DUP);
      put_entry('h10e, 16'h0107, "drop", OP_DROP);
      put_entry('h116, 16'h010e, "swap", OP_SWAP);
      put_entry('h11e, 16'h0116, "+",    OP_ADD);
      put_entry('h123, 16'h011e, "-",    OP_SUB);
      put_str('h200, "abcdefghijklmnopqrst");

      #12;
      chk("rst.bsy", 32'(bsy_o), 0);
      chk("rst.done", 32'(done_o), 0);
      chk("rst.ai", 32'(bus.ai), 0);
      chk("rst.we", 32'(bus.we), 0);
      expect_res("rst", 0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      start(0, 'h123);     wait_done("num", lat);
      expect_res("num", 0, 0, 0, 0, 3, 3);

      start(3, 'h123);     wait_done("dup", lat);
      expect_res("dup", 1, 0, OP_DUP, 'h10d, 3, 7);
      chk("dup.we", 32'(bus.we), 0);

      start(7, 'h123);     wait_done("add", lat);
      expect_res("add", 1, 0, OP_ADD, 'h122, 1, 9);

      start(13, 'h123);    wait_done("sub", lat);
      expect_res("sub", 1, 0, OP_SUB, 'h127, 1, 15);

      start(15, 'h123);    wait_done("eot", lat);
      expect_res("eot", 0, 1, 0, 0, 0, 15);
      chk("eot.latency", 32'(lat), 32'd3);

      start(3, 'h1ffff);   wait_done("ctx_end", lat);
      expect_res("ctx_end", 0, 0, 0, 0, 3, 7);

      start('h200, 'h123); wait_done("long", lat);
      expect_res("long", 0, 0, 0, 0, 20, 'h214);

      // en while busy must not restart the search
      start(7, 'h123);
      repeat (4) @(negedge clk_i);
      tib_ptr_i = 0;
      ctx_i     = 'h1ffff;
      en_i      = 1'b1;
      @(negedge clk_i);
      en_i      = 1'b0;
      wait_done("en_busy", lat);
      expect_res("en_busy", 1, 0, OP_ADD, 'h122, 1, 9);

      // reset lands while comparing the "dup" name bytes
      start(3, 'h123);
      repeat (28) @(posedge clk_i);
      #1;
      chk("midrst.bsy_before", 32'(bsy_o), 1);
      rst_ni = 1'b0;
      #2;
      chk("midrst.bsy", 32'(bsy_o), 0);
      chk("midrst.ai", 32'(bus.ai), 0);
      expect_res("midrst", 0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i);
         #1;
         if (done_o) dn++;
      end
      chk("midrst.no_done", 32'(dn), 0);

      start(3, 'h123);     wait_done("after_rst", lat);
      expect_res("after_rst", 1, 0, OP_DUP, 'h10d, 3, 7);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
